// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the program counter, issues word reads to
// instruction memory over a req/ack handshake, and drives the IF/OF pipeline
// register. A stalled return is parked in a one-entry hold buffer, and a
// redirect that arrives while a read is in flight makes the stage wait for
// that read and discard it.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_INC   = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        is_branch_taken,
    input  logic [31:0] branch_pc,
    output logic        if_of_valid,
    output logic [31:0] if_of_instruction,
    output logic [31:0] if_of_pc
);

    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_HOLD  = 2'b01,
        S_DROP  = 2'b10
    } state_t;

    localparam logic [31:0] PC_STEP = 32'(PC_INC);

    // Clear the two low address bits so every fetch is word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

    state_t      state_r,       state_s;
    logic [31:0] pc_r,          pc_s;
    logic [31:0] drop_addr_r,   drop_addr_s;
    logic [31:0] hold_instr_r,  hold_instr_s;
    logic [31:0] hold_pc_r,     hold_pc_s;
    logic        valid_r,       valid_s;
    logic [31:0] instr_r,       instr_s;
    logic [31:0] of_pc_r,       of_pc_s;

    logic [31:0] pc_next_seq_s;
    logic [31:0] branch_target_s;

    // Sequential successor (wraps modulo 2^32) and aligned redirect target.
    always_comb begin
        pc_next_seq_s   = pc_r + PC_STEP;
        branch_target_s = align_word(branch_pc);
    end

    // Next-state and register-update decode for the fetch FSM.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        drop_addr_s  = drop_addr_r;
        hold_instr_s = hold_instr_r;
        hold_pc_s    = hold_pc_r;
        valid_s      = valid_r;
        instr_s      = instr_r;
        of_pc_s      = of_pc_r;

        case (state_r)
            S_FETCH: begin
                if (is_branch_taken) begin
                    // Redirect wins over everything, including stall.
                    valid_s = 1'b0;
                    pc_s    = branch_target_s;
                    if (!imem_ack) begin
                        // The request at pc is still in flight; wait it out.
                        drop_addr_s = pc_r;
                        state_s     = S_DROP;
                    end else begin
                        // Returned word is wrong-path; just drop it.
                        state_s = S_FETCH;
                    end
                end else if (imem_ack && !stall) begin
                    instr_s = imem_rdata;
                    of_pc_s = pc_r;
                    valid_s = 1'b1;
                    pc_s    = pc_next_seq_s;
                end else if (imem_ack && stall) begin
                    // OF is busy: park the word and stop requesting.
                    hold_instr_s = imem_rdata;
                    hold_pc_s    = pc_r;
                    pc_s         = pc_next_seq_s;
                    state_s      = S_HOLD;
                end else if (!stall) begin
                    valid_s = 1'b0;
                end else begin
                    valid_s = valid_r;
                end
            end

            S_HOLD: begin
                if (is_branch_taken) begin
                    hold_instr_s = 32'h0000_0000;
                    hold_pc_s    = 32'h0000_0000;
                    valid_s      = 1'b0;
                    pc_s         = branch_target_s;
                    state_s      = S_FETCH;
                end else if (!stall) begin
                    instr_s      = hold_instr_r;
                    of_pc_s      = hold_pc_r;
                    valid_s      = 1'b1;
                    hold_instr_s = 32'h0000_0000;
                    hold_pc_s    = 32'h0000_0000;
                    state_s      = S_FETCH;
                end else begin
                    state_s = S_HOLD;
                end
            end

            S_DROP: begin
                valid_s = 1'b0;
                if (is_branch_taken) begin
                    pc_s = branch_target_s;
                end else begin
                    pc_s = pc_r;
                end
                if (imem_ack) begin
                    state_s = S_FETCH;
                end else begin
                    state_s = S_DROP;
                end
            end

            default: begin
                valid_s = 1'b0;
                state_s = S_FETCH;
            end
        endcase
    end

    // State, program counter, hold buffer and IF/OF pipeline register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= S_FETCH;
            pc_r         <= RESET_PC;
            drop_addr_r  <= 32'h0000_0000;
            hold_instr_r <= 32'h0000_0000;
            hold_pc_r    <= 32'h0000_0000;
            valid_r      <= 1'b0;
            instr_r      <= 32'h0000_0000;
            of_pc_r      <= 32'h0000_0000;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            drop_addr_r  <= drop_addr_s;
            hold_instr_r <= hold_instr_s;
            hold_pc_r    <= hold_pc_s;
            valid_r      <= valid_s;
            instr_r      <= instr_s;
            of_pc_r      <= of_pc_s;
        end
    end

    // Memory request decodes straight from state so a fetch can issue the
    // cycle after reset and the cycle after every accepted return.
    always_comb begin
        imem_req  = (state_r == S_FETCH) || (state_r == S_DROP);
        if (state_r == S_DROP) begin
            imem_addr = drop_addr_r;
        end else begin
            imem_addr = pc_r;
        end
    end

    assign if_of_valid       = valid_r;
    assign if_of_instruction = instr_r;
    assign if_of_pc          = of_pc_r;

endmodule
